// File: rtl/axi_slave_pkg.sv
// Shared types, default widths and address decode helper for the AXI4-Lite SRAM slave.
package axi_slave_pkg;

    localparam int unsigned AXI_ID_BITS   = 8;
    localparam int unsigned AXI_DATA_BITS = 32;
    localparam int unsigned AXI_ADDR_BITS = 32;
    localparam int unsigned AXI_MEM_WORDS = 16384;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_DATA = 2'd1,
        WR_DATA = 2'd2,
        WR_RESP = 2'd3
    } slv_state_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        DECERR = 2'b11
    } resp_e;

    // Widened compare so the byte limit cannot overflow the address width.
    function automatic logic addr_decerr(input logic [AXI_ADDR_BITS-1:0] addr,
                                         input int unsigned             words);
        return {2'b00, addr} >= (34'(words) << 2);
    endfunction

endpackage

// File: rtl/sram_bank.sv
// Word-addressed single-port-per-direction SRAM: byte-enable write, registered 1-cycle read.
module sram_bank #(
    parameter int unsigned  WORDS     = 16384,
    parameter int unsigned  DATA_BITS = 32,
    localparam int unsigned IDX_BITS  = $clog2(WORDS),
    localparam int unsigned STRB_BITS = DATA_BITS / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 re_i,
    input  logic [IDX_BITS-1:0]  raddr_i,
    output logic [DATA_BITS-1:0] rdata_o,
    input  logic                 we_i,
    input  logic [IDX_BITS-1:0]  waddr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic [STRB_BITS-1:0] wstrb_i
);

    logic [DATA_BITS-1:0] mem_q [WORDS];
    logic [DATA_BITS-1:0] rdata_q;

    // Array is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(STRB_BITS); b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite single-outstanding slave in front of a word SRAM; round-robin between
// reads and writes when both arrive together, OKAY/DECERR responses with ID echo.
module axi_lite_sram_slave
    import axi_slave_pkg::*;
#(
    parameter int unsigned  ID_BITS   = AXI_ID_BITS,
    parameter int unsigned  DATA_BITS = AXI_DATA_BITS,
    parameter int unsigned  MEM_WORDS = AXI_MEM_WORDS,
    localparam int unsigned STRB_BITS = DATA_BITS / 8,
    localparam int unsigned IDX_BITS  = $clog2(MEM_WORDS)
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [ID_BITS-1:0]       AWID,
    input  logic [AXI_ADDR_BITS-1:0] AWADDR,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [DATA_BITS-1:0]     WDATA,
    input  logic [STRB_BITS-1:0]     WSTRB,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [ID_BITS-1:0]       BID,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [ID_BITS-1:0]       ARID,
    input  logic [AXI_ADDR_BITS-1:0] ARADDR,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [ID_BITS-1:0]       RID,
    output logic [DATA_BITS-1:0]     RDATA,
    output logic [1:0]               RRESP,
    output logic                     RVALID,
    input  logic                     RREADY
);

    slv_state_e           state_q,  state_d;
    logic                 rr_q,     rr_d;
    logic [ID_BITS-1:0]   rid_q,    rid_d;
    logic [ID_BITS-1:0]   bid_q,    bid_d;
    resp_e                rresp_q,  rresp_d;
    resp_e                bresp_q,  bresp_d;
    logic                 rvalid_q, rvalid_d;
    logic                 bvalid_q, bvalid_d;
    logic                 wready_q, wready_d;
    logic [IDX_BITS-1:0]  wr_idx_q, wr_idx_d;
    logic                 wr_err_q, wr_err_d;

    logic                 grant_rd;
    logic                 grant_wr;
    logic                 rd_err;
    logic                 wr_err;
    logic                 sram_re;
    logic                 sram_we;
    logic [DATA_BITS-1:0] sram_rdata;

    assign rd_err = addr_decerr(ARADDR, MEM_WORDS);
    assign wr_err = addr_decerr(AWADDR, MEM_WORDS);

    // rr_q remembers the last granted type; a simultaneous request goes to the other one.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state_q == IDLE) begin
            grant_rd = ARVALID && (!AWVALID || !rr_q);
            grant_wr = AWVALID && (!ARVALID ||  rr_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        rid_d    = rid_q;
        bid_d    = bid_q;
        rresp_d  = rresp_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        bvalid_d = bvalid_q;
        wready_d = wready_q;
        wr_idx_d = wr_idx_q;
        wr_err_d = wr_err_q;
        case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    state_d  = RD_DATA;
                    rr_d     = 1'b1;
                    rid_d    = ARID;
                    rresp_d  = rd_err ? DECERR : OKAY;
                    rvalid_d = 1'b1;
                end else if (grant_wr) begin
                    state_d  = WR_DATA;
                    rr_d     = 1'b0;
                    bid_d    = AWID;
                    wr_idx_d = AWADDR[2 +: IDX_BITS];
                    wr_err_d = wr_err;
                    wready_d = 1'b1;
                end
            end
            RD_DATA: begin
                if (RREADY) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            WR_DATA: begin
                if (WVALID) begin
                    wready_d = 1'b0;
                    bvalid_d = 1'b1;
                    bresp_d  = wr_err_q ? DECERR : OKAY;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BREADY) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            rid_q    <= '0;
            bid_q    <= '0;
            rresp_q  <= OKAY;
            bresp_q  <= OKAY;
            rvalid_q <= 1'b0;
            bvalid_q <= 1'b0;
            wready_q <= 1'b0;
            wr_idx_q <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            rid_q    <= rid_d;
            bid_q    <= bid_d;
            rresp_q  <= rresp_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            bvalid_q <= bvalid_d;
            wready_q <= wready_d;
            wr_idx_q <= wr_idx_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign sram_re = grant_rd && !rd_err;
    assign sram_we = wready_q && WVALID && !wr_err_q;

    sram_bank #(
        .WORDS     (MEM_WORDS),
        .DATA_BITS (DATA_BITS)
    ) sram_u (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .re_i    (sram_re),
        .raddr_i (ARADDR[2 +: IDX_BITS]),
        .rdata_o (sram_rdata),
        .we_i    (sram_we),
        .waddr_i (wr_idx_q),
        .wdata_i (WDATA),
        .wstrb_i (WSTRB)
    );

    assign AWREADY = grant_wr;
    assign ARREADY = grant_rd;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign RVALID  = rvalid_q;
    assign RID     = rid_q;
    assign RRESP   = rresp_q;
    // Out-of-range reads never touch the SRAM, so mask its stale output.
    assign RDATA   = (rresp_q == DECERR) ? '0 : sram_rdata;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave: data path, byte strobes, arbitration,
// backpressure, decode errors and reset during a pending response.
module tb_axi_lite_sram_slave;

    logic        ACLK;
    logic        ARESET;
    logic [7:0]  AWID;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [7:0]  ARID;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    int checks = 0;
    int errors = 0;

    localparam int BOUND = 20;

    axi_lite_sram_slave dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .AWID    (AWID),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BID     (BID),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARID    (ARID),
        .ARADDR  (ARADDR),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RID     (RID),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end at posedge+1.
    task automatic axi_write(input logic [7:0] id, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb,
                             output logic [7:0] bid, output logic [1:0] bresp);
        int n;
        AWID = id; AWADDR = addr; AWVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!AWREADY && n < BOUND) begin @(negedge ACLK); n++; end
        if (!AWREADY) chk("aw_timeout", 0, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WDATA = data; WSTRB = strb; WVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!WREADY && n < BOUND) begin @(negedge ACLK); n++; end
        if (!WREADY) chk("w_timeout", 0, 1);
        @(posedge ACLK); #1;
        WVALID = 1'b0; BREADY = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!BVALID && n < BOUND) begin @(negedge ACLK); n++; end
        if (!BVALID) chk("b_timeout", 0, 1);
        bid = BID; bresp = BRESP;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] id, input logic [31:0] addr,
                            output logic [31:0] data, output logic [7:0] rid,
                            output logic [1:0] rresp, output int lat);
        int n;
        ARID = id; ARADDR = addr; ARVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!ARREADY && n < BOUND) begin @(negedge ACLK); n++; end
        if (!ARREADY) chk("ar_timeout", 0, 1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0; RREADY = 1'b1;
        lat = 0;
        do begin @(negedge ACLK); lat++; end while (!RVALID && lat < BOUND);
        if (!RVALID) chk("r_timeout", 0, 1);
        data = RDATA; rid = RID; rresp = RRESP;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
    endtask

    logic [7:0]  bid_o, rid_o;
    logic [1:0]  bresp_o, rresp_o;
    logic [31:0] rdata_o;
    int          lat_o;
    logic [1:0]  grant;
    int          n;
    logic [1:0]  exp_order [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

    initial begin
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        #12;
        chk("rst_arready", ARREADY, 0);
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready",  WREADY,  0);
        chk("rst_bvalid",  BVALID,  0);
        chk("rst_rvalid",  RVALID,  0);
        chk("rst_rdata",   RDATA,   0);
        chk("rst_rid",     RID,     0);
        chk("rst_bid",     BID,     0);
        chk("rst_resp",    {RRESP, BRESP}, 0);
        #10 ARESET = 1'b0;
        @(posedge ACLK); #1;

        // Full write then read-back with ID echo and one-cycle read latency.
        axi_write(8'd3, 32'h10, 32'hDEADBEEF, 4'hF, bid_o, bresp_o);
        chk("t1_bid", bid_o, 8'd3);
        chk("t1_bresp", bresp_o, 2'b00);
        axi_read(8'd5, 32'h10, rdata_o, rid_o, rresp_o, lat_o);
        chk("t1_rdata", rdata_o, 32'hDEADBEEF);
        chk("t1_rid", rid_o, 8'd5);
        chk("t1_rresp", rresp_o, 2'b00);
        chk("t1_lat", lat_o, 1);

        // Byte strobes, zero strobe, low address bits ignored.
        axi_write(8'd1, 32'h20, 32'h11223344, 4'hF, bid_o, bresp_o);
        axi_write(8'd2, 32'h20, 32'hAABBCCDD, 4'b0101, bid_o, bresp_o);
        axi_read(8'd6, 32'h20, rdata_o, rid_o, rresp_o, lat_o);
        chk("t2_strb", rdata_o, 32'h11BB33DD);
        axi_write(8'd4, 32'h20, 32'hFFFFFFFF, 4'h0, bid_o, bresp_o);
        chk("t2_strb0_bresp", bresp_o, 2'b00);
        axi_read(8'd7, 32'h23, rdata_o, rid_o, rresp_o, lat_o);
        chk("t2_strb0_rdata", rdata_o, 32'h11BB33DD);

        // R backpressure: response held, no new AR accepted while stalled.
        ARID = 8'd9; ARADDR = 32'h10; ARVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!ARREADY && n < BOUND) begin @(negedge ACLK); n++; end
        if (!ARREADY) chk("t4_ar_timeout", 0, 1);
        @(posedge ACLK); #1;
        ARID = 8'd10;
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            chk("t4_rvalid", RVALID, 1);
            chk("t4_rdata", RDATA, 32'hDEADBEEF);
            chk("t4_rid", RID, 8'd9);
            chk("t4_arready", ARREADY, 0);
            @(posedge ACLK); #1;
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        chk("t4_arready_hs", ARREADY, 0);
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        @(negedge ACLK);
        chk("t4_arready_back", ARREADY, 1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0; RREADY = 1'b1;
        @(negedge ACLK);
        chk("t4_rid2", RID, 8'd10);
        @(posedge ACLK); #1;
        RREADY = 1'b0;

        // Out-of-range address: DECERR, zero data, no write aliasing onto word 0.
        axi_read(8'd7, 32'h0001_0000, rdata_o, rid_o, rresp_o, lat_o);
        chk("t5_rresp", rresp_o, 2'b11);
        chk("t5_rdata", rdata_o, 32'h0);
        chk("t5_rid", rid_o, 8'd7);
        axi_write(8'd8, 32'h0, 32'h01234567, 4'hF, bid_o, bresp_o);
        axi_write(8'd9, 32'h0001_0000, 32'hCAFEF00D, 4'hF, bid_o, bresp_o);
        chk("t5_bresp", bresp_o, 2'b11);
        chk("t5_bid", bid_o, 8'd9);
        axi_read(8'd1, 32'h0, rdata_o, rid_o, rresp_o, lat_o);
        chk("t5_word0", rdata_o, 32'h01234567);
        chk("t5_word0_resp", rresp_o, 2'b00);

        // Simultaneous AR and AW from reset alternate starting with read.
        do_reset();
        ARID = 8'h21; ARADDR = 32'h10; ARVALID = 1'b1;
        AWID = 8'h22; AWADDR = 32'h40; AWVALID = 1'b1;
        WDATA = 32'h600D600D; WSTRB = 4'hF; WVALID = 1'b1;
        RREADY = 1'b1; BREADY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge ACLK);
            while (!(ARREADY || AWREADY) && n < BOUND) begin @(negedge ACLK); n++; end
            grant = {ARREADY, AWREADY};
            chk($sformatf("t3_grant%0d", k), grant, exp_order[k]);
            @(posedge ACLK);
        end
        #1;
        ARVALID = 1'b0; AWVALID = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        WVALID = 1'b0; RREADY = 1'b0; BREADY = 1'b0;

        // Reset while B is pending: response dropped, committed data survives.
        AWID = 8'h2C; AWADDR = 32'h30; AWVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!AWREADY && n < BOUND) begin @(negedge ACLK); n++; end
        if (!AWREADY) chk("t6_aw_timeout", 0, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WDATA = 32'h5A5AA5A5; WSTRB = 4'hF; WVALID = 1'b1;
        @(posedge ACLK); #1;
        WVALID = 1'b0;
        @(negedge ACLK);
        chk("t6_bvalid_pre", BVALID, 1);
        #2 ARESET = 1'b1;
        #1;
        chk("t6_bvalid_rst", BVALID, 0);
        chk("t6_bid_rst", BID, 0);
        @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("t6_bvalid_post", BVALID, 0);
        @(posedge ACLK); #1;
        axi_read(8'h33, 32'h30, rdata_o, rid_o, rresp_o, lat_o);
        chk("t6_rdata", rdata_o, 32'h5A5AA5A5);
        chk("t6_rid", rid_o, 8'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
